ddr_rw_arbiter: RTL and testbench

Single-port arbiter that shares the DDR3 controller's AXI-style user interface between the video-capture write requester and the display read requester. It sits between the frame-buffer FIFOs and the DDR IP user port in the `core_clk` domain. It grants one burst at a time with round-robin fairness and drives the address channel. It counts data beats to detect burst completion, and a watchdog recovers from a stalled burst.

---
 rtl/ddr_rw_arbiter.sv | 145 ++++++++++++++
 tb/tb_ddr_rw_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rw_arbiter.sv
// ddr_rw_arbiter: round-robin single-burst arbiter between write and read requesters on a DDR user port
module ddr_rw_arbiter #(
  parameter int ADDR_WIDTH = 28,
  parameter int LEN_WIDTH = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                  core_clk,
  input  logic                  rst,
  input  logic                  ddr_init_done,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [LEN_WIDTH-1:0]  wr_len,
  output logic                  wr_grant,
  output logic                  wr_done,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [LEN_WIDTH-1:0]  rd_len,
  output logic                  rd_grant,
  output logic                  rd_done,
  output logic [ADDR_WIDTH-1:0] axi_awaddr,
  output logic [LEN_WIDTH-1:0]  axi_awlen,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  input  logic                  axi_w_beat,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic [LEN_WIDTH-1:0]  axi_arlen,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  input  logic                  axi_r_beat,
  output logic                  busy,
  output logic                  timeout_err
);
  localparam int WD_W = $clog2(TIMEOUT);
  typedef enum logic [2:0] {IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA} state_t;
  state_t state, state_d;
  logic last_rd, last_rd_d, wr_cmp, wr_cmp_d;
  logic [LEN_WIDTH-1:0] cnt, cnt_d, awlen_d, arlen_d;
  logic [WD_W-1:0] wdog, wdog_d;
  logic [ADDR_WIDTH-1:0] awaddr_d, araddr_d;
  logic wr_grant_d, rd_grant_d, wr_done_d, rd_done_d, timeout_d;
  logic expire, wr_last, rd_last;
  assign expire = wdog == WD_W'(TIMEOUT - 1);
  assign wr_last = axi_w_beat && cnt == axi_awlen;
  assign rd_last = axi_r_beat && cnt == axi_arlen;
  assign axi_awvalid = state == WR_ADDR;
  assign axi_arvalid = state == RD_ADDR;
  assign busy = state != IDLE;
  always_comb begin
    state_d = state;
    last_rd_d = last_rd;
    cnt_d = cnt;
    wdog_d = state == IDLE ? wdog : wdog + WD_W'(1);
    wr_cmp_d = wr_cmp;
    awaddr_d = axi_awaddr;
    awlen_d = axi_awlen;
    araddr_d = axi_araddr;
    arlen_d = axi_arlen;
    wr_grant_d = 1'b0;
    rd_grant_d = 1'b0;
    wr_done_d = 1'b0;
    rd_done_d = 1'b0;
    timeout_d = 1'b0;
    case (state)
      IDLE: if (ddr_init_done && (wr_req || rd_req)) begin
        cnt_d = '0;
        wdog_d = '0;
        wr_cmp_d = 1'b0;
        if (wr_req && (!rd_req || last_rd)) begin
          state_d = WR_ADDR;
          wr_grant_d = 1'b1;
          awaddr_d = wr_addr;
          awlen_d = wr_len;
          last_rd_d = 1'b0;
        end else begin
          state_d = RD_ADDR;
          rd_grant_d = 1'b1;
          araddr_d = rd_addr;
          arlen_d = rd_len;
          last_rd_d = 1'b1;
        end
      end
      // write data may beat the address handshake; completion is remembered in wr_cmp
      WR_ADDR: begin
        if (axi_w_beat && !wr_cmp) begin
          cnt_d = wr_last ? cnt : cnt + LEN_WIDTH'(1);
          wr_cmp_d = wr_last;
        end
        if (axi_awready) begin
          state_d = WR_DATA;
          wr_done_d = wr_cmp || wr_last;
        end
      end
      WR_DATA: if (wr_cmp) state_d = IDLE;
      else if (wr_last) begin
        state_d = IDLE;
        wr_done_d = 1'b1;
      end else if (axi_w_beat) cnt_d = cnt + LEN_WIDTH'(1);
      RD_ADDR: if (axi_arready) state_d = RD_DATA;
      RD_DATA: if (rd_last) begin
        state_d = IDLE;
        rd_done_d = 1'b1;
      end else if (axi_r_beat) cnt_d = cnt + LEN_WIDTH'(1);
      default: state_d = IDLE;
    endcase
    if (state != IDLE && expire) begin
      state_d = IDLE;
      timeout_d = 1'b1;
      wr_done_d = 1'b0;
      rd_done_d = 1'b0;
    end
  end
  always_ff @(posedge core_clk) begin
    if (rst) begin
      state <= IDLE;
      last_rd <= 1'b1;
      cnt <= '0;
      wdog <= '0;
      wr_cmp <= 1'b0;
      axi_awaddr <= '0;
      axi_awlen <= '0;
      axi_araddr <= '0;
      axi_arlen <= '0;
      wr_grant <= 1'b0;
      rd_grant <= 1'b0;
      wr_done <= 1'b0;
      rd_done <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_d;
      last_rd <= last_rd_d;
      cnt <= cnt_d;
      wdog <= wdog_d;
      wr_cmp <= wr_cmp_d;
      axi_awaddr <= awaddr_d;
      axi_awlen <= awlen_d;
      axi_araddr <= araddr_d;
      axi_arlen <= arlen_d;
      wr_grant <= wr_grant_d;
      rd_grant <= rd_grant_d;
      wr_done <= wr_done_d;
      rd_done <= rd_done_d;
      timeout_err <= timeout_d;
    end
  end
endmodule

// File: tb/tb_ddr_rw_arbiter.sv
// tb_ddr_rw_arbiter: directed scenario bench for ddr_rw_arbiter (watchdog shortened to 64 cycles)
module tb_ddr_rw_arbiter;
  logic core_clk = 1'b0, rst = 1'b1, ddr_init_done = 1'b0;
  logic wr_req = 1'b0, rd_req = 1'b0;
  logic [27:0] wr_addr = '0, rd_addr = '0;
  logic [3:0] wr_len = '0, rd_len = '0;
  logic wr_grant, wr_done, rd_grant, rd_done;
  logic [27:0] axi_awaddr, axi_araddr;
  logic [3:0] axi_awlen, axi_arlen;
  logic axi_awvalid, axi_arvalid, busy, timeout_err;
  logic axi_awready = 1'b0, axi_arready = 1'b0, axi_w_beat = 1'b0, axi_r_beat = 1'b0;
  logic [71:0] outs;
  int checks = 0, errors = 0;
  assign outs = {wr_grant, wr_done, rd_grant, rd_done, axi_awaddr, axi_awlen, axi_awvalid,
                 axi_araddr, axi_arlen, axi_arvalid, busy, timeout_err};
  always #5 core_clk = ~core_clk;
  ddr_rw_arbiter #(.ADDR_WIDTH(28), .LEN_WIDTH(4), .TIMEOUT(64)) dut (
    .core_clk(core_clk), .rst(rst), .ddr_init_done(ddr_init_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_len(wr_len), .wr_grant(wr_grant), .wr_done(wr_done),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_len(rd_len), .rd_grant(rd_grant), .rd_done(rd_done),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid),
    .axi_awready(axi_awready), .axi_w_beat(axi_w_beat),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_r_beat(axi_r_beat),
    .busy(busy), .timeout_err(timeout_err)
  );
  task automatic step();
    @(posedge core_clk);
    #1;
  endtask
  task automatic do_reset();
    {wr_req, rd_req, axi_awready, axi_arready, axi_w_beat, axi_r_beat} = '0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    ddr_init_done = 1'b0;
    do_reset();
    checks++;
    if (outs !== '0) begin errors++; $display("FAIL reset_outs: got %h expected 0", outs); end
    wr_req = 1'b1;
    wr_addr = 28'h0000040;
    wr_len = 4'd0;
    for (int i = 0; i < 50; i++) begin
      step();
      checks++;
      if (outs !== '0) begin errors++; $display("FAIL init_hold cycle %0d: got %h expected 0", i, outs); end
    end
    ddr_init_done = 1'b1;
    step();
    checks++;
    if ({wr_grant, axi_awvalid, busy} !== 3'b111) begin errors++; $display("FAIL init_grant: got %b expected 111", {wr_grant, axi_awvalid, busy}); end
    wr_req = 1'b0;
    axi_awready = 1'b1;
    step();
    axi_awready = 1'b0;
    axi_w_beat = 1'b1;
    step();
    axi_w_beat = 1'b0;
    checks++;
    if ({wr_done, busy} !== 2'b10) begin errors++; $display("FAIL init_done: got %b expected 10", {wr_done, busy}); end
  endtask
  task automatic test_single_write();
    wr_addr = 28'h0001000;
    wr_len = 4'd7;
    wr_req = 1'b1;
    step();
    wr_req = 1'b0;
    checks++;
    if ({wr_grant, axi_awvalid, axi_awaddr, axi_awlen} !== {2'b11, 28'h0001000, 4'd7}) begin
      errors++; $display("FAIL sw_grant: got %b %h %h expected 11 0001000 7", {wr_grant, axi_awvalid}, axi_awaddr, axi_awlen);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({wr_grant, axi_awvalid, axi_awaddr, axi_awlen} !== {2'b01, 28'h0001000, 4'd7}) begin
        errors++; $display("FAIL sw_hold %0d: got %b %h %h expected 01 0001000 7", i, {wr_grant, axi_awvalid}, axi_awaddr, axi_awlen);
      end
    end
    axi_awready = 1'b1;
    step();
    axi_awready = 1'b0;
    checks++;
    if ({axi_awvalid, busy} !== 2'b01) begin errors++; $display("FAIL sw_handshake: got %b expected 01", {axi_awvalid, busy}); end
    axi_w_beat = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (wr_done !== (i == 7)) begin errors++; $display("FAIL sw_done beat %0d: got %b expected %b", i, wr_done, i == 7); end
    end
    axi_w_beat = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL sw_busy_done: got %b expected 0", busy); end
    step();
    checks++;
    if ({wr_done, busy} !== 2'b00) begin errors++; $display("FAIL sw_after: got %b expected 00", {wr_done, busy}); end
  endtask
  task automatic test_round_robin();
    do_reset();
    ddr_init_done = 1'b1;
    wr_len = 4'd3;
    rd_len = 4'd3;
    wr_addr = 28'h0002000;
    rd_addr = 28'h0003000;
    axi_awready = 1'b1;
    axi_arready = 1'b1;
    wr_req = 1'b1;
    rd_req = 1'b1;
    step();
    for (int b = 0; b < 4; b++) begin
      logic is_wr;
      is_wr = b[0] == 1'b0;
      checks++;
      if ({wr_grant, rd_grant} !== (is_wr ? 2'b10 : 2'b01)) begin
        errors++; $display("FAIL rr_grant %0d: got %b expected %b", b, {wr_grant, rd_grant}, is_wr ? 2'b10 : 2'b01);
      end
      checks++;
      if ((is_wr ? axi_awaddr : axi_araddr) !== (is_wr ? 28'h0002000 : 28'h0003000)) begin
        errors++; $display("FAIL rr_addr %0d: got %h", b, is_wr ? axi_awaddr : axi_araddr);
      end
      step();
      axi_w_beat = is_wr;
      axi_r_beat = !is_wr;
      for (int k = 0; k < 4; k++) begin
        step();
        checks++;
        if ((is_wr ? wr_done : rd_done) !== (k == 3)) begin
          errors++; $display("FAIL rr_done %0d beat %0d: got %b expected %b", b, k, is_wr ? wr_done : rd_done, k == 3);
        end
      end
      axi_w_beat = 1'b0;
      axi_r_beat = 1'b0;
      step();
    end
    wr_req = 1'b0;
    rd_req = 1'b0;
  endtask
  task automatic test_early_write();
    do_reset();
    wr_len = 4'd3;
    wr_addr = 28'h0004000;
    wr_req = 1'b1;
    step();
    wr_req = 1'b0;
    axi_w_beat = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if ({wr_done, axi_awvalid} !== 2'b01) begin errors++; $display("FAIL early_beat %0d: got %b expected 01", i, {wr_done, axi_awvalid}); end
    end
    axi_w_beat = 1'b0;
    step();
    axi_awready = 1'b1;
    step();
    axi_awready = 1'b0;
    checks++;
    if ({wr_done, busy} !== 2'b11) begin errors++; $display("FAIL early_done: got %b expected 11", {wr_done, busy}); end
    step();
    checks++;
    if ({wr_done, busy} !== 2'b00) begin errors++; $display("FAIL early_idle: got %b expected 00", {wr_done, busy}); end
  endtask
  task automatic test_watchdog();
    int seen_done;
    seen_done = 0;
    do_reset();
    rd_len = 4'd15;
    rd_addr = 28'h0005000;
    wr_len = 4'd0;
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    wr_req = 1'b1;
    checks++;
    if (rd_grant !== 1'b1) begin errors++; $display("FAIL wd_grant: got %b expected 1", rd_grant); end
    for (int t = 1; t <= 64; t++) begin
      axi_arready = t == 1;
      axi_r_beat = t >= 2 && t <= 6;
      step();
      if (rd_done) seen_done++;
      if (t < 64) begin
        checks++;
        if ({timeout_err, busy, wr_grant} !== 3'b010) begin errors++; $display("FAIL wd_early t=%0d: got %b expected 010", t, {timeout_err, busy, wr_grant}); end
      end
    end
    checks++;
    if ({timeout_err, busy, axi_arvalid} !== 3'b100) begin errors++; $display("FAIL wd_abort: got %b expected 100", {timeout_err, busy, axi_arvalid}); end
    axi_arready = 1'b0;
    axi_r_beat = 1'b0;
    step();
    wr_req = 1'b0;
    checks++;
    if ({wr_grant, timeout_err} !== 2'b10) begin errors++; $display("FAIL wd_next_grant: got %b expected 10", {wr_grant, timeout_err}); end
    checks++;
    if (seen_done !== 0) begin errors++; $display("FAIL wd_no_done: got %0d expected 0", seen_done); end
  endtask
  task automatic test_stray_beats();
    do_reset();
    axi_r_beat = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({rd_done, busy} !== 2'b00) begin errors++; $display("FAIL stray_idle %0d: got %b expected 00", i, {rd_done, busy}); end
    end
    axi_r_beat = 1'b0;
    wr_len = 4'd1;
    wr_req = 1'b1;
    step();
    wr_req = 1'b0;
    axi_awready = 1'b1;
    step();
    axi_awready = 1'b0;
    axi_w_beat = 1'b1;
    axi_r_beat = 1'b1;
    step();
    checks++;
    if ({rd_done, wr_done} !== 2'b00) begin errors++; $display("FAIL stray_wdata1: got %b expected 00", {rd_done, wr_done}); end
    step();
    checks++;
    if ({rd_done, wr_done} !== 2'b01) begin errors++; $display("FAIL stray_wdata2: got %b expected 01", {rd_done, wr_done}); end
    axi_w_beat = 1'b0;
    axi_r_beat = 1'b0;
    rd_len = 4'd1;
    rd_req = 1'b1;
    step();
    rd_req = 1'b0;
    checks++;
    if ({rd_grant, axi_arvalid} !== 2'b11) begin errors++; $display("FAIL stray_rgrant: got %b expected 11", {rd_grant, axi_arvalid}); end
    axi_r_beat = 1'b1;
    step();
    axi_arready = 1'b1;
    step();
    axi_arready = 1'b0;
    checks++;
    if ({rd_done, axi_arvalid, busy} !== 3'b001) begin errors++; $display("FAIL stray_raddr: got %b expected 001", {rd_done, axi_arvalid, busy}); end
    step();
    checks++;
    if ({rd_done, busy} !== 2'b01) begin errors++; $display("FAIL stray_rbeat1: got %b expected 01", {rd_done, busy}); end
    step();
    axi_r_beat = 1'b0;
    checks++;
    if ({rd_done, busy} !== 2'b10) begin errors++; $display("FAIL stray_rbeat2: got %b expected 10", {rd_done, busy}); end
  endtask
  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_early_write();
    test_watchdog();
    test_stray_beats();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
